uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin packet arbiter that shares the single UART transmit FIFO write port between N_REQ byte-stream requesters. A requester holds its grant until it writes a byte flagged last, so packets never interleave on the wire. A stall watchdog revokes a grant whose owner stops supplying bytes mid-packet. Sits between the client logic and the uart top-level txfifo write interface (wen/wdata/full).

Parameters:
N_REQ, 4, number of requesters (2..16)
IDLE_TIMEOUT, 1024, cycles without valid from the granted requester before the grant is revoked; 0 disables the watchdog
ID_W, $clog2(N_REQ), width of requester index (derived; not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
i_req_valid  input  N_REQ  per-requester byte valid
i_req_data  input  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k]
i_req_last  input  N_REQ  per-requester last-byte-of-packet flag
o_req_ready  output  N_REQ  per-requester byte accepted this cycle when valid&ready
o_txfifo_wen  output  1  txfifo write enable
o_txfifo_wdata  output  8  txfifo write data
i_txfifo_full  input  1  txfifo full
o_grant  output  N_REQ  one-hot current owner; all zero when idle
o_busy  output  1  high while a grant is held
o_abort  output  1  one-cycle pulse when the watchdog revokes a grant
o_abort_id  output  ID_W  index of the revoked requester; valid while o_abort=1

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All state updates on the rising edge of clk.
- Reset: state=IDLE, grant=0, rr_ptr=N_REQ-1, stall counter=0, o_abort=0, o_abort_id=0. Outputs while in reset: o_req_ready=0, o_txfifo_wen=0, o_txfifo_wdata=0, o_grant=0, o_busy=0. Asserting rst mid-packet drops the grant on that edge; any partial packet is not completed.
- FSM states: IDLE, XFER.
- IDLE: if any i_req_valid, select the first valid index searching from rr_ptr+1 upward, wrapping modulo N_REQ. Register it as owner g, set o_grant one-hot, go to XFER. No byte is accepted in IDLE. Selecting an owner takes 1 cycle.
- XFER: o_req_ready[g] = !i_txfifo_full; all other ready bits are 0. o_txfifo_wen = i_req_valid[g] & !i_txfifo_full. o_txfifo_wdata = data slice g, combinational, and 0 when not XFER. A transfer is wen=1.
- Transfer with i_req_last[g]=1: on that edge set rr_ptr=g, clear the grant, and go to IDLE. The minimum gap between packets is 1 IDLE cycle.
- Watchdog, when IDLE_TIMEOUT>0: the counter increments each XFER cycle with i_req_valid[g]=0. It clears on any transfer and on entering XFER. Cycles stalled on i_txfifo_full with valid=1 do not count.
- Watchdog expiry: when the counter reaches IDLE_TIMEOUT, on that edge go to IDLE, set rr_ptr=g, clear the grant, and pulse o_abort=1 for exactly 1 cycle with o_abort_id=g.
- After an abort, the next byte from g is treated as the start of a new packet.
- Counter width is $clog2(IDLE_TIMEOUT+1). The counter saturates and never wraps.
- Fairness: after owner g releases, every other valid requester is served before g again.
- Simultaneous requests: priority is strictly rotational from rr_ptr+1; there is no fixed priority except the first grant after reset (index 0 first).
- Valid from a non-owner is ignored; its ready stays 0 and it must hold its data.
- i_txfifo_full asserted mid-packet: the grant is held and wen=0 until not full.
- last with full=1: the byte is not transferred and the grant is held.
- N_REQ=1: arbitration degenerates to a single requester with packet framing and the watchdog still active.

Test Plan:
- Single packet: req1 sends 0x11,0x22,0x33(last), full=0 -> grant=0010 1 cycle after valid; wen on 3 consecutive cycles with wdata 11,22,33; o_busy falls the cycle after 0x33.
- Round-robin: all 4 requesters valid with 2-byte packets right after reset -> grant order 0,1,2,3,0; each packet is contiguous in the txfifo byte stream with no interleaving.
- Backpressure: i_txfifo_full=1 for 5 cycles mid-packet -> o_req_ready[g]=0 and wen=0 for those 5 cycles; grant holds; no byte is lost or duplicated; the watchdog does not fire.
- Watchdog: IDLE_TIMEOUT=8; req2 sends 1 byte without last, then drops valid -> o_abort=1 exactly 8 cycles after the last transfer with o_abort_id=2; grant clears; req3 (pending) is granted next.
- Reset mid-packet: rst for 1 cycle during req0's second byte -> next cycle grant=0, wen=0, busy=0; afterwards req0 is again first priority.
- Contention with non-owner: req3 valid throughout req1's 4-byte packet -> o_req_ready[3]=0 throughout; req3 is granted 1 cycle after req1's last byte.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin packet arbiter sharing the single UART txfifo write port between
// N_REQ byte-stream requesters. An owner keeps its grant until it writes a byte
// flagged last, so packets never interleave. A stall watchdog revokes the grant
// of an owner that stops supplying bytes mid-packet.
module uart_tx_arbiter #(
    parameter  int N_REQ        = 4,
    parameter  int IDLE_TIMEOUT = 1024,
    localparam int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_data,
    input  logic [N_REQ-1:0]     i_req_last,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic                 o_txfifo_wen,
    output logic [7:0]           o_txfifo_wdata,
    input  logic                 i_txfifo_full,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_abort,
    output logic [ID_W-1:0]      o_abort_id
);

    // The stall counter only needs to reach IDLE_TIMEOUT; keep at least one bit
    // so the design still elaborates when the watchdog is disabled.
    localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT) : '0;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_owner;
    logic [N_REQ-1:0]  r_grant;
    logic [ID_W-1:0]   r_rrPtr;
    logic [CNT_W-1:0]  r_stallCnt;
    logic              r_abort;
    logic [ID_W-1:0]   r_abortId;

    logic              w_found;
    logic [ID_W-1:0]   w_nextIdx;
    logic [ID_W-1:0]   w_cand;
    logic              w_ownerValid;
    logic              w_ownerLast;
    logic [7:0]        w_ownerData;
    logic              w_active;
    logic              w_xfer;
    logic              w_expire;

    // Rotational search for the next owner, starting one past the last owner.
    always_comb begin
        w_found   = 1'b0;
        w_nextIdx = '0;
        w_cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = ID_W'((int'(r_rrPtr) + i) % N_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_nextIdx = w_cand;
            end
        end
    end

    // Pick out the current owner's valid, last flag and data byte via the one-hot grant.
    always_comb begin
        w_ownerValid = |(i_req_valid & r_grant);
        w_ownerLast  = |(i_req_last & r_grant);
        w_ownerData  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) begin
                w_ownerData = w_ownerData | i_req_data[8*k +: 8];
            end
        end
    end

    // Write-port steering; everything is forced quiet while reset is held.
    always_comb begin
        w_active       = (r_state == XFER) && !rst;
        w_xfer         = w_active && w_ownerValid && !i_txfifo_full;
        w_expire       = (IDLE_TIMEOUT > 0) && w_active && !w_ownerValid
                         && (r_stallCnt == CNT_LAST);
        o_req_ready    = (w_active && !i_txfifo_full) ? r_grant : '0;
        o_txfifo_wen   = w_xfer;
        o_txfifo_wdata = w_active ? w_ownerData : 8'h00;
        o_grant        = rst ? '0 : r_grant;
        o_busy         = w_active;
        o_abort        = r_abort;
        o_abort_id     = r_abortId;
    end

    // Arbitration FSM: grant in IDLE, hold through the packet in XFER, release on
    // last byte or watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_grant    <= '0;
            r_rrPtr    <= ID_W'(N_REQ - 1);
            r_stallCnt <= '0;
            r_abort    <= 1'b0;
            r_abortId  <= '0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner            <= w_nextIdx;
                        r_grant            <= '0;
                        r_grant[w_nextIdx] <= 1'b1;
                        r_stallCnt         <= '0;
                        r_state            <= XFER;
                    end
                end
                XFER: begin
                    if (w_xfer) begin
                        r_stallCnt <= '0;
                        if (w_ownerLast) begin
                            r_rrPtr <= r_owner;
                            r_grant <= '0;
                            r_state <= IDLE;
                        end
                    end else if (w_expire) begin
                        r_rrPtr    <= r_owner;
                        r_grant    <= '0;
                        r_stallCnt <= '0;
                        r_abort    <= 1'b1;
                        r_abortId  <= r_owner;
                        r_state    <= IDLE;
                    end else if ((IDLE_TIMEOUT > 0) && !w_ownerValid && (r_stallCnt != CNT_MAX)) begin
                        r_stallCnt <= r_stallCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter: simple per-requester packet sources feed
// the arbiter and the txfifo byte stream is logged and compared with
// hand-computed sequences.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  reqValid;
   logic [8*N-1:0] reqData;
   logic [N-1:0]  reqLast;
   logic [N-1:0]  reqReady;
   logic          txWen;
   logic [7:0]    txWdata;
   logic          txFull;
   logic [N-1:0]  grant;
   logic          busy;
   logic          abortPulse;
   logic [1:0]    abortId;

   logic [7:0]    srcMem [N][8];
   bit            srcLast [N][8];
   int            srcLen [N];
   int            srcPtr [N];
   bit            srcEn [N];

   logic [7:0]    txLog [$];
   logic [7:0]    expQ [$];

   int            checkCount;
   int            passCount;

   uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_req_valid    (reqValid),
      .i_req_data     (reqData),
      .i_req_last     (reqLast),
      .o_req_ready    (reqReady),
      .o_txfifo_wen   (txWen),
      .o_txfifo_wdata (txWdata),
      .i_txfifo_full  (txFull),
      .o_grant        (grant),
      .o_busy         (busy),
      .o_abort        (abortPulse),
      .o_abort_id     (abortId)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and count the result.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present each enabled source's current byte on the requester ports.
   task automatic applyStimulus();
      for (int k = 0; k < N; k++) begin
         if (srcEn[k] && srcPtr[k] < srcLen[k]) begin
            reqValid[k]       = 1'b1;
            reqData[8*k +: 8] = srcMem[k][srcPtr[k]];
            reqLast[k]        = srcLast[k][srcPtr[k]];
         end else begin
            reqValid[k] = 1'b0;
            reqLast[k]  = 1'b0;
         end
      end
   endtask

   task automatic setByte(input int k, input int idx, input logic [7:0] data, input bit last);
      srcMem[k][idx]  = data;
      srcLast[k][idx] = last;
   endtask

   task automatic loadPkt(input int k, input int len);
      srcLen[k] = len;
      srcPtr[k] = 0;
      srcEn[k]  = 1'b1;
   endtask

   // One clock: capture handshakes before the edge, then advance sources and log bytes.
   task automatic tick();
      logic [N-1:0] acc;
      logic         w;
      logic [7:0]   d;
      acc = reqReady & reqValid;
      w   = txWen;
      d   = txWdata;
      @(posedge clk);
      #1;
      if (w) txLog.push_back(d);
      for (int k = 0; k < N; k++) begin
         if (acc[k]) srcPtr[k]++;
      end
      applyStimulus();
      #1;
   endtask

   // Compare the logged txfifo stream with expQ, then clear the log.
   task automatic checkLog(input string tag);
      checkOutput({tag, "Len"}, txLog.size(), expQ.size());
      for (int i = 0; i < expQ.size(); i++) begin
         checkOutput(tag, (i < txLog.size()) ? {24'h0, txLog[i]} : 32'hDEAD, {24'h0, expQ[i]});
      end
      txLog.delete();
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst        = 1'b1;
      txFull     = 1'b0;
      reqValid   = '0;
      reqData    = '0;
      reqLast    = '0;
      for (int k = 0; k < N; k++) begin
         srcLen[k] = 0;
         srcPtr[k] = 0;
         srcEn[k]  = 1'b0;
      end

      // Reset state, with a requester valid that must be ignored.
      setByte(1, 0, 8'hEE, 1'b1);
      loadPkt(1, 1);
      applyStimulus();
      #1;
      tick();
      tick();
      checkOutput("rstGrant", grant, 4'b0000);
      checkOutput("rstBusy", busy, 1'b0);
      checkOutput("rstWen", txWen, 1'b0);
      checkOutput("rstReady", reqReady, 4'b0000);
      checkOutput("rstAbort", abortPulse, 1'b0);
      checkOutput("rstAbortId", abortId, 2'd0);
      srcEn[1] = 1'b0;
      applyStimulus();
      rst = 1'b0;
      #1;
      txLog.delete();

      // Single packet from requester 1.
      setByte(1, 0, 8'h11, 1'b0);
      setByte(1, 1, 8'h22, 1'b0);
      setByte(1, 2, 8'h33, 1'b1);
      loadPkt(1, 3);
      applyStimulus();
      #1;
      checkOutput("spIdleWen", txWen, 1'b0);
      tick();
      checkOutput("spGrant", grant, 4'b0010);
      checkOutput("spWdata0", txWdata, 8'h11);
      tick();
      checkOutput("spWdata1", txWdata, 8'h22);
      tick();
      checkOutput("spWdata2", txWdata, 8'h33);
      checkOutput("spBusyHeld", busy, 1'b1);
      tick();
      checkOutput("spBusyFall", busy, 1'b0);
      checkOutput("spGrantClr", grant, 4'b0000);
      expQ = '{8'h11, 8'h22, 8'h33};
      checkLog("spLog");

      // Round-robin from reset: four requesters, requester 0 has a second packet.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      setByte(0, 0, 8'hA0, 1'b0); setByte(0, 1, 8'hA1, 1'b1);
      setByte(0, 2, 8'hA2, 1'b0); setByte(0, 3, 8'hA3, 1'b1);
      setByte(1, 0, 8'hB0, 1'b0); setByte(1, 1, 8'hB1, 1'b1);
      setByte(2, 0, 8'hC0, 1'b0); setByte(2, 1, 8'hC1, 1'b1);
      setByte(3, 0, 8'hD0, 1'b0); setByte(3, 1, 8'hD1, 1'b1);
      loadPkt(0, 4); loadPkt(1, 2); loadPkt(2, 2); loadPkt(3, 2);
      applyStimulus();
      #1;
      txLog.delete();
      begin
         logic [3:0] order [5];
         order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
         for (int p = 0; p < 5; p++) begin
            tick();
            checkOutput($sformatf("rrGrant%0d", p), grant, order[p]);
            tick();
            tick();
         end
      end
      expQ = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hA2, 8'hA3};
      checkLog("rrLog");
      for (int k = 0; k < N; k++) srcEn[k] = 1'b0;

      // Backpressure: full for 5 cycles in the middle of requester 2's packet.
      setByte(2, 0, 8'h51, 1'b0); setByte(2, 1, 8'h52, 1'b0);
      setByte(2, 2, 8'h53, 1'b0); setByte(2, 3, 8'h54, 1'b1);
      loadPkt(2, 4);
      applyStimulus();
      #1;
      tick();
      checkOutput("bpGrant", grant, 4'b0100);
      tick();
      for (int i = 0; i < 5; i++) begin
         txFull = 1'b1;
         #1;
         checkOutput($sformatf("bpReady%0d", i), reqReady, 4'b0000);
         checkOutput($sformatf("bpWen%0d", i), txWen, 1'b0);
         checkOutput($sformatf("bpHold%0d", i), grant, 4'b0100);
         checkOutput($sformatf("bpAbort%0d", i), abortPulse, 1'b0);
         tick();
      end
      txFull = 1'b0;
      #1;
      checkOutput("bpResume", txWdata, 8'h52);
      tick();
      tick();
      tick();
      checkOutput("bpDone", busy, 1'b0);
      expQ = '{8'h51, 8'h52, 8'h53, 8'h54};
      checkLog("bpLog");

      // Watchdog: requester 2 sends one byte without last and goes quiet.
      setByte(2, 0, 8'h61, 1'b0);
      loadPkt(2, 1);
      applyStimulus();
      #1;
      tick();
      checkOutput("wdGrant", grant, 4'b0100);
      checkOutput("wdWen", txWen, 1'b1);
      setByte(3, 0, 8'h71, 1'b1);
      loadPkt(3, 1);
      applyStimulus();
      #1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         checkOutput($sformatf("wdNoAbort%0d", c), abortPulse, 1'b0);
      end
      checkOutput("wdHeld", grant, 4'b0100);
      tick();
      checkOutput("wdAbort", abortPulse, 1'b1);
      checkOutput("wdAbortId", abortId, 2'd2);
      checkOutput("wdGrantClr", grant, 4'b0000);
      checkOutput("wdBusy", busy, 1'b0);
      tick();
      checkOutput("wdAbortEnd", abortPulse, 1'b0);
      checkOutput("wdNext", grant, 4'b1000);
      tick();
      expQ = '{8'h61, 8'h71};
      checkLog("wdLog");

      // Reset during requester 0's second byte while requester 1 waits.
      setByte(0, 0, 8'h81, 1'b0); setByte(0, 1, 8'h82, 1'b0); setByte(0, 2, 8'h83, 1'b1);
      loadPkt(0, 3);
      applyStimulus();
      #1;
      tick();
      checkOutput("mrGrant", grant, 4'b0001);
      setByte(1, 0, 8'h91, 1'b1);
      loadPkt(1, 1);
      applyStimulus();
      #1;
      checkOutput("mrReady", reqReady, 4'b0001);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("mrRstWen", txWen, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("mrGrantClr", grant, 4'b0000);
      checkOutput("mrWen", txWen, 1'b0);
      checkOutput("mrBusy", busy, 1'b0);
      tick();
      checkOutput("mrFirst", grant, 4'b0001);
      checkOutput("mrData", txWdata, 8'h82);
      tick();
      tick();
      tick();
      checkOutput("mrSecond", grant, 4'b0010);
      tick();
      expQ = '{8'h81, 8'h82, 8'h83, 8'h91};
      checkLog("mrLog");

      // Contention: requester 3 waits throughout requester 1's 4-byte packet.
      setByte(1, 0, 8'hC1, 1'b0); setByte(1, 1, 8'hC2, 1'b0);
      setByte(1, 2, 8'hC3, 1'b0); setByte(1, 3, 8'hC4, 1'b1);
      loadPkt(1, 4);
      applyStimulus();
      #1;
      tick();
      setByte(3, 0, 8'hD1, 1'b1);
      loadPkt(3, 1);
      applyStimulus();
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("ctReady%0d", i), reqReady, 4'b0010);
         checkOutput($sformatf("ctData%0d", i), txWdata, 8'hC1 + 8'(i));
         tick();
      end
      checkOutput("ctIdle", grant, 4'b0000);
      checkOutput("ctIdleReady", reqReady, 4'b0000);
      tick();
      checkOutput("ctNext", grant, 4'b1000);
      tick();
      expQ = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1};
      checkLog("ctLog");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
